// File: rtl/shift_pkg.sv
// Shared definitions for the shift line: mode encodings and a small helper.
package shift_pkg;

    // Operating modes selected by the 2-bit mode input.
    typedef enum logic [1:0] {
        MODE_HOLD   = 2'b00,
        MODE_SHIFT  = 2'b01,
        MODE_ROTATE = 2'b10,
        MODE_CLEAR  = 2'b11
    } mode_e;

    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_DEPTH = 4;

    // True for the modes that advance every stage by one position.
    function automatic logic mode_moves(input mode_e m);
        return (m == MODE_SHIFT) || (m == MODE_ROTATE);
    endfunction

endpackage : shift_pkg

// File: rtl/sat_cnt.sv
// Saturating up-counter with synchronous clear; counts 0..MAX and never wraps.
module sat_cnt #(
    parameter int MAX = 4,
    parameter int CW  = $clog2(MAX + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          inc,
    input  logic          clr,
    output logic [CW-1:0] cnt
);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count: clear wins over increment, increment stops at MAX.
    always_comb begin
        // NOTE: default first so every path assigns cnt_d and no latch is inferred.
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q < CW'(MAX))) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Count register, cleared asynchronously by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values together.
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule : sat_cnt

// File: rtl/shift_line_n.sv
// DEPTH-stage shift line with shift, rotate, clear and hold modes, a
// combinational tap port and a saturating count of valid stages.
module shift_line_n
    import shift_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH,
    localparam int CW   = $clog2(DEPTH + 1),
    localparam int SW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic [SW-1:0]    tap_sel,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_tap,
    output logic [CW-1:0]    fill_cnt,
    output logic             full
);

    mode_e mode_s;
    logic  move_fire;
    logic  rotate_fire;
    logic  shift_fire;
    logic  clear_fire;

    logic [WIDTH-1:0] stage_q [DEPTH];
    logic [WIDTH-1:0] stage_d [DEPTH];

    assign mode_s      = mode_e'(mode);
    assign move_fire   = en && mode_moves(mode_s);
    assign rotate_fire = en && (mode_s == MODE_ROTATE);
    assign shift_fire  = en && (mode_s == MODE_SHIFT);
    assign clear_fire  = en && (mode_s == MODE_CLEAR);

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        logic [WIDTH-1:0] prev_s;

        // Stage 0 takes d on shift or the last stage on rotate; others take their neighbour.
        if (i == 0) begin : g_head
            assign prev_s = rotate_fire ? stage_q[DEPTH-1] : d;
        end else begin : g_body
            assign prev_s = stage_q[i-1];
        end

        assign stage_d[i] = clear_fire ? '0 :
                            move_fire  ? prev_s :
                                         stage_q[i];

        // Stage register; all stages advance on the same edge.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                // NOTE: the stage array is reset because contents must read zero during reset.
                stage_q[i] <= '0;
            end else begin
                stage_q[i] <= stage_d[i];
            end
        end
    end

    // Valid-stage counter: grows on shift, zeroed on clear, untouched by rotate.
    sat_cnt #(
        .MAX (DEPTH),
        .CW  (CW)
    ) u_fill (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (shift_fire),
        .clr   (clear_fire),
        .cnt   (fill_cnt)
    );

    // Tap mux; indices past the last stage read as zero.
    always_comb begin
        q_tap = '0;
        if (int'(tap_sel) < DEPTH) begin
            q_tap = stage_q[tap_sel];
        end
    end

    assign q    = stage_q[DEPTH-1];
    assign full = (fill_cnt == CW'(DEPTH));

endmodule : shift_line_n

// File: tb/tb_shift_line_n.sv
// Self-checking bench for shift_line_n with WIDTH=8, DEPTH=4.
module tb_shift_line_n;
    import shift_pkg::*;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;

    logic             clk;
    logic             rst_n;
    logic             en;
    logic [1:0]       mode;
    logic [WIDTH-1:0] d;
    logic [1:0]       tap_sel;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] q_tap;
    logic [2:0]       fill_cnt;
    logic             full;

    int n_checks = 0;
    int n_pass   = 0;

    shift_line_n #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .mode     (mode),
        .d        (d),
        .tap_sel  (tap_sel),
        .q        (q),
        .q_tap    (q_tap),
        .fill_cnt (fill_cnt),
        .full     (full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       en;
        logic [1:0] mode;
        logic [7:0] d;
        logic [1:0] tap;
        logic [7:0] exp_q;
        logic [7:0] exp_tap;
        logic [2:0] exp_cnt;
        logic       exp_full;
    } vec_t;

    vec_t vecs[13];

    // Behavioural reference: index 0 is stage 0, index DEPTH-1 drives q.
    logic [7:0] m_line[$];
    int         m_cnt;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic e, input logic [1:0] m, input logic [7:0] dv,
                                input logic [1:0] t, input logic [7:0] eq, input logic [7:0] et,
                                input logic [2:0] ec, input logic ef);
        vec_t v;
        v.en = e; v.mode = m; v.d = dv; v.tap = t;
        v.exp_q = eq; v.exp_tap = et; v.exp_cnt = ec; v.exp_full = ef;
        return v;
    endfunction

    task automatic model_reset();
        m_line.delete();
        for (int i = 0; i < DEPTH; i++) m_line.push_back(8'h00);
        m_cnt = 0;
    endtask

    task automatic model_edge(input logic e, input logic [1:0] m, input logic [7:0] dv);
        logic [7:0] last;
        if (!e) return;
        case (m)
            2'b01: begin
                m_line.push_front(dv);
                last = m_line.pop_back();
                if (m_cnt < DEPTH) m_cnt++;
            end
            2'b10: begin
                last = m_line.pop_back();
                m_line.push_front(last);
            end
            2'b11: begin
                for (int i = 0; i < DEPTH; i++) m_line[i] = 8'h00;
                m_cnt = 0;
            end
            default: ;
        endcase
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
    endtask

    task automatic drive(input logic e, input logic [1:0] m, input logic [7:0] dv, input logic [1:0] t);
        en = e; mode = m; d = dv; tap_sel = t;
    endtask

    task automatic load_four();
        do_reset();
        drive(1'b1, MODE_SHIFT, 8'h11, 2'd0); tick();
        drive(1'b1, MODE_SHIFT, 8'h22, 2'd0); tick();
        drive(1'b1, MODE_SHIFT, 8'h33, 2'd0); tick();
        drive(1'b1, MODE_SHIFT, 8'h44, 2'd0); tick();
    endtask

    initial begin
        logic [7:0] hist[$];
        logic [7:0] exp_taps[4];

        vecs[0]  = mk(1'b1, MODE_SHIFT,  8'h11, 2'd0, 8'h00, 8'h11, 3'd1, 1'b0);
        vecs[1]  = mk(1'b1, MODE_SHIFT,  8'h22, 2'd1, 8'h00, 8'h11, 3'd2, 1'b0);
        vecs[2]  = mk(1'b1, MODE_SHIFT,  8'h33, 2'd2, 8'h00, 8'h11, 3'd3, 1'b0);
        vecs[3]  = mk(1'b1, MODE_SHIFT,  8'h44, 2'd3, 8'h11, 8'h11, 3'd4, 1'b1);
        vecs[4]  = mk(1'b1, MODE_SHIFT,  8'h55, 2'd0, 8'h22, 8'h55, 3'd4, 1'b1);
        vecs[5]  = mk(1'b1, MODE_HOLD,   8'hFF, 2'd0, 8'h22, 8'h55, 3'd4, 1'b1);
        vecs[6]  = mk(1'b0, MODE_SHIFT,  8'hFF, 2'd1, 8'h22, 8'h44, 3'd4, 1'b1);
        vecs[7]  = mk(1'b1, MODE_CLEAR,  8'hFF, 2'd0, 8'h00, 8'h00, 3'd0, 1'b0);
        vecs[8]  = mk(1'b1, MODE_SHIFT,  8'hA5, 2'd0, 8'h00, 8'hA5, 3'd1, 1'b0);
        vecs[9]  = mk(1'b1, MODE_ROTATE, 8'h5A, 2'd0, 8'h00, 8'h00, 3'd1, 1'b0);
        vecs[10] = mk(1'b1, MODE_ROTATE, 8'h5A, 2'd2, 8'h00, 8'hA5, 3'd1, 1'b0);
        vecs[11] = mk(1'b1, MODE_ROTATE, 8'h5A, 2'd3, 8'hA5, 8'hA5, 3'd1, 1'b0);
        vecs[12] = mk(1'b1, MODE_ROTATE, 8'h5A, 2'd0, 8'h00, 8'hA5, 3'd1, 1'b0);

        rst_n = 1'b0;
        drive(1'b0, MODE_HOLD, 8'h00, 2'd0);
        #12;
        check("reset_q",    int'(q),        0);
        check("reset_tap",  int'(q_tap),    0);
        check("reset_cnt",  int'(fill_cnt), 0);
        check("reset_full", int'(full),     0);
        rst_n = 1'b1;

        // Table-driven vectors, one edge each, from the post-reset state.
        for (int i = 0; i < 13; i++) begin
            drive(vecs[i].en, vecs[i].mode, vecs[i].d, vecs[i].tap);
            tick();
            check($sformatf("vec%0d_q", i),    int'(q),        int'(vecs[i].exp_q));
            check($sformatf("vec%0d_tap", i),  int'(q_tap),    int'(vecs[i].exp_tap));
            check($sformatf("vec%0d_cnt", i),  int'(fill_cnt), int'(vecs[i].exp_cnt));
            check($sformatf("vec%0d_full", i), int'(full),     int'(vecs[i].exp_full));
        end

        // Enable gating: en=0 with SHIFT and d=FF must freeze the line.
        load_four();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, MODE_SHIFT, 8'hFF, 2'd0);
            tick();
            check("engate_q",   int'(q),        8'h11);
            check("engate_cnt", int'(fill_cnt), 4);
            check("engate_tap", int'(q_tap),    8'h44);
        end

        // Rotate four times: one step shows the wrap, four restore the contents.
        drive(1'b1, MODE_ROTATE, 8'hEE, 2'd0);
        tick();
        check("rot1_q",   int'(q),     8'h22);
        check("rot1_tap", int'(q_tap), 8'h11);
        for (int i = 0; i < 3; i++) tick();
        exp_taps = '{8'h44, 8'h33, 8'h22, 8'h11};
        drive(1'b0, MODE_HOLD, 8'h00, 2'd0);
        for (int t = 0; t < 4; t++) begin
            tap_sel = 2'(t);
            #1;
            check($sformatf("rot4_tap%0d", t), int'(q_tap), int'(exp_taps[t]));
        end
        check("rot4_cnt", int'(fill_cnt), 4);
        check("rot4_q",   int'(q),        8'h11);

        // Clear a full line, then a single shift.
        drive(1'b1, MODE_CLEAR, 8'h99, 2'd0);
        tick();
        drive(1'b0, MODE_HOLD, 8'h00, 2'd0);
        for (int t = 0; t < 4; t++) begin
            tap_sel = 2'(t);
            #1;
            check($sformatf("clr_tap%0d", t), int'(q_tap), 0);
        end
        check("clr_cnt",  int'(fill_cnt), 0);
        check("clr_full", int'(full),     0);
        drive(1'b1, MODE_SHIFT, 8'hA5, 2'd0);
        tick();
        check("clrsh_cnt", int'(fill_cnt), 1);
        check("clrsh_tap", int'(q_tap),    8'hA5);
        check("clrsh_q",   int'(q),        8'h00);

        // Reset asserted between edges clears immediately; first edge after release works.
        load_four();
        drive(1'b0, MODE_HOLD, 8'h00, 2'd3);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_q",   int'(q),        0);
        check("midrst_tap", int'(q_tap),    0);
        check("midrst_cnt", int'(fill_cnt), 0);
        rst_n = 1'b1;
        drive(1'b1, MODE_SHIFT, 8'h77, 2'd0);
        tick();
        check("postrst_tap", int'(q_tap),    8'h77);
        check("postrst_cnt", int'(fill_cnt), 1);
        check("postrst_q",   int'(q),        0);

        // Pure shift latency: q must show d from exactly DEPTH-1 edges earlier.
        do_reset();
        hist.delete();
        for (int n = 0; n < 20; n++) begin
            drive(1'b1, MODE_SHIFT, 8'($urandom), 2'd0);
            hist.push_back(d);
            tick();
            if (hist.size() >= DEPTH)
                check($sformatf("lag%0d", n), int'(q), int'(hist[hist.size() - DEPTH]));
        end

        // Random mixed traffic against the queue model.
        do_reset();
        model_reset();
        for (int n = 0; n < 200; n++) begin
            int r;
            logic [1:0] m;
            r = int'($urandom_range(0, 9));
            if (r < 5)      m = MODE_SHIFT;
            else if (r < 7) m = MODE_ROTATE;
            else if (r < 8) m = MODE_CLEAR;
            else            m = MODE_HOLD;
            drive(($urandom_range(0, 9) != 0), m, 8'($urandom), 2'($urandom_range(0, 3)));
            model_edge(en, mode, d);
            tick();
            check($sformatf("rnd%0d_q", n),    int'(q),        int'(m_line[DEPTH-1]));
            check($sformatf("rnd%0d_tap", n),  int'(q_tap),    int'(m_line[tap_sel]));
            check($sformatf("rnd%0d_cnt", n),  int'(fill_cnt), m_cnt);
            check($sformatf("rnd%0d_full", n), int'(full),     (m_cnt == DEPTH) ? 1 : 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_shift_line_n

// File: doc/shift_line_n.md
SHIFT_LINE_N -- requirements
Module: shift_line_n

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set the data width in bits (WIDTH >= 1).
REQ-002 Parameter DEPTH, default 4, SHALL set the number of register stages (DEPTH >= 2).
REQ-003 Derived constant CW = $clog2(DEPTH+1) SHALL size fill_cnt.
REQ-004 Derived constant SW = $clog2(DEPTH) SHALL size tap_sel.
REQ-005 Ports SHALL be as follows:
- clk  input  1  — rising-edge clock, the only clock
- rst_n  input  1  — reset, asynchronous, active-low
- en  input  1  — cycle enable; 0 = hold everything
- mode  input  2  — 00 HOLD, 01 SHIFT, 10 ROTATE, 11 CLEAR
- d  input  WIDTH  — serial data into stage 0
- tap_sel  input  SW  — stage index for q_tap
- q  output  WIDTH  — stage DEPTH-1 contents
- q_tap  output  WIDTH  — contents of stage tap_sel
- fill_cnt  output  CW  — number of valid stages, 0..DEPTH
- full  output  1  — fill_cnt == DEPTH

Function
REQ-006 Every stage update SHALL be non-blocking and SHALL occur only on the rising edge of clk, so all stages advance simultaneously and no stage sees a same-edge update.
REQ-007 When en=0, all stages and fill_cnt SHALL hold, regardless of mode.
REQ-008 With en=1 and mode HOLD, all stages and fill_cnt SHALL hold.
REQ-009 With en=1 and mode SHIFT:
- stage[0] <= d
- stage[i] <= stage[i-1] for 1 <= i < DEPTH
- fill_cnt <= min(fill_cnt+1, DEPTH), saturating and never wrapping
REQ-010 With en=1 and mode ROTATE:
- stage[0] <= stage[DEPTH-1]
- stage[i] <= stage[i-1] for 1 <= i < DEPTH
- d is ignored
- fill_cnt is unchanged
REQ-011 With en=1 and mode CLEAR, all stages <= 0 and fill_cnt <= 0 on the same edge.
REQ-012 Latency: a value presented on d with SHIFT on edge k SHALL appear on q after edge k+DEPTH-1, given DEPTH consecutive SHIFT cycles.
REQ-013 q SHALL be a direct wire from stage[DEPTH-1], with no extra register.
REQ-014 q_tap SHALL be combinational: stage[tap_sel] when tap_sel < DEPTH, else all-zero.
REQ-015 full SHALL be combinational from fill_cnt.
REQ-016 A change of en, mode or d between edges SHALL have no effect until the next rising edge.

Reset
REQ-017 While rst_n=0, all stages SHALL be 0 and fill_cnt SHALL be 0, asynchronously, independent of clk. As a consequence q=0, q_tap=0 and full=0.
REQ-018 Reset asserted mid-operation SHALL discard all contents immediately.
REQ-019 After rst_n deasserts, the first rising edge SHALL be processed normally.

Structure
REQ-020 The mode encodings (MODE_HOLD, MODE_SHIFT, MODE_ROTATE, MODE_CLEAR) SHALL live in shared package shift_pkg.
REQ-021 The saturating fill counter SHALL be sub-module sat_cnt, with parameters MAX and CW and ports clk, rst_n, inc, clr, cnt.
REQ-022 The stage array SHALL be a single generate-indexed register array in shift_line_n.

Verification
All scenarios use WIDTH=8, DEPTH=4.
REQ-023 Reset mid-run: with stages holding nonzero data, assert rst_n=0 between edges -> q, q_tap and fill_cnt go to 0 before the next edge.
REQ-024 SHIFT sequence 0x11, 0x22, 0x33, 0x44, 0x55, one value per edge:
- after the 4th edge: q=0x11, full=1, fill_cnt=4
- after the 5th edge: q=0x22, fill_cnt stays 4
REQ-025 Enable gating: after loading 0x11..0x44, drive en=0 with mode=SHIFT and d=0xFF for 3 edges -> q stays 0x11 and fill_cnt stays 4.
REQ-026 ROTATE: with stages [0..3] = 44, 33, 22, 11, apply ROTATE for 4 edges:
- after edge 1: q=0x22, q_tap(tap_sel=0)=0x11
- after edge 4: original contents restored, fill_cnt unchanged
REQ-027 CLEAR then SHIFT: with the line full, apply CLEAR for one edge -> all stages 0, fill_cnt=0, full=0. Then SHIFT 0xA5 once -> fill_cnt=1, q_tap(tap_sel=0)=0xA5, q=0x00.
REQ-028 Comparison against a blocking-assignment reference model: with identical random d applied under SHIFT for 20 edges, q SHALL lag d by exactly DEPTH-1 edges after the write (REQ-012). A 1-edge collapse indicates a blocking-assignment error.
